// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared definitions for the AES core arbiter slice.
//   - AES block / key widths
//   - mode encodings driven to the core's key-size mux
//   - sequencing state enum
//   - mode legality helper
package aes_arb_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_KEY_W   = 256;

    typedef enum logic [1:0] {
        MODE_128     = 2'b00,
        MODE_192     = 2'b01,
        MODE_256     = 2'b10,
        MODE_ILLEGAL = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    function automatic logic mode_is_legal(input logic [1:0] mode);
        return mode != MODE_ILLEGAL;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: 2-way round-robin grant.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   valid        : requests (already masked by the caller to grant windows)
//   update       : load the last-served pointer with 'served'
//   served       : requester index that was just served
//   grant        : one-hot grant, combinational from valid and the pointer
// The pointer holds the last-served requester; its reset value 1 makes
// requester 0 win the first contention.
module aes_rr_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    logic last_served;

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last_served ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_served <= 1'b1;
        end else if (update) begin
            last_served <= served;
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES encryption core between two requesters.
// Jobs are accepted round-robin in IDLE, the core is reset for one cycle with
// the job operands applied (LOAD), the finish flag is awaited (RUN), and the
// result is handed back to the owner (RESP).
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready           : per-requester job handshake (ready is a 1-cycle one-hot pulse)
//   req_block/req_key/req_mode    : per-requester plaintext, key, key-size mode (11 = illegal)
//   rsp_valid/rsp_ready           : per-requester result handshake
//   rsp_data/rsp_err              : shared result and error flag
//   core_rst/core_key/core_mux/core_in : drive the core (reset active high)
//   core_out/core_done            : core result and sticky finish flag
// Optional build macro AES_ARB_WATCHDOG_EN: abort a RUN that lasts
// TIMEOUT_CYCLES cycles without core_done, answering with an error.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 127
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0][AES_BLOCK_W-1:0] req_block,
    input  logic [1:0][AES_KEY_W-1:0]   req_key,
    input  logic [1:0][1:0]             req_mode,
    output logic [1:0]                  rsp_valid,
    input  logic [1:0]                  rsp_ready,
    output logic [AES_BLOCK_W-1:0]      rsp_data,
    output logic                        rsp_err,
    output logic                        core_rst,
    output logic [AES_KEY_W-1:0]        core_key,
    output logic [1:0]                  core_mux,
    output logic [AES_BLOCK_W-1:0]      core_in,
    input  logic [AES_BLOCK_W-1:0]      core_out,
    input  logic                        core_done
);

    // The watchdog counter is 8 bits wide.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..256");
    end

    arb_state_e state;
    logic       owner;
    logic       run_first;
    logic [1:0] arb_valid;
    logic [1:0] grant;
    logic       sel;
    logic       rsp_fire;

`ifdef AES_ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;
`endif

    // Grants are only offered in IDLE, so accept and operand capture happen
    // in the same cycle that req_ready is shown.
    assign arb_valid = (state == ST_IDLE) ? req_valid : 2'b00;
    assign sel       = grant[1];
    assign req_ready = grant;
    assign rsp_fire  = (state == ST_RESP) && rsp_ready[owner];

    aes_rr_arbiter u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (arb_valid),
        .update  (rsp_fire),
        .served  (owner),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            run_first <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            core_rst  <= 1'b1;
            core_key  <= '0;
            core_mux  <= '0;
            core_in   <= '0;
`ifdef AES_ARB_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    core_rst <= 1'b0;
                    if (grant != 2'b00) begin
                        owner <= sel;
                        if (!mode_is_legal(req_mode[sel])) begin
                            // Illegal mode: answer immediately, core operands untouched.
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= grant;
                            state     <= ST_RESP;
                        end else begin
                            core_key <= req_key[sel];
                            core_mux <= req_mode[sel];
                            core_in  <= req_block[sel];
                            core_rst <= 1'b1;
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    core_rst  <= 1'b0;
                    run_first <= 1'b1;
`ifdef AES_ARB_WATCHDOG_EN
                    wd_cnt    <= '0;
`endif
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    run_first <= 1'b0;
                    // The finish flag may still be stale from the previous job
                    // during the first RUN cycle.
                    if (!run_first && core_done) begin
                        rsp_data  <= core_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        state     <= ST_RESP;
                    end
`ifdef AES_ARB_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        core_rst  <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                ST_RESP: begin
                    core_rst <= 1'b0;
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
